// File: rtl/desired_drive_seq_if.sv
// Signal bundle between the sensor-conditioning side and the target-current sequencer.
interface desired_drive_seq_if;
  logic        start;
  logic [11:0] avg_torque;
  logic [4:0]  cadence;
  logic        not_pedaling;
  logic [12:0] incline;
  logic [2:0]  scale;
  logic        busy;
  logic        done;
  logic [11:0] target_curr;

  modport master (
    output start, avg_torque, cadence, not_pedaling, incline, scale,
    input  busy, done, target_curr
  );

  modport slave (
    input  start, avg_torque, cadence, not_pedaling, incline, scale,
    output busy, done, target_curr
  );
endinterface

// File: rtl/desired_drive_seq.sv
// eBike motor target-current sequencer: one shared 27x9 multiplier stepped over three products.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | derive torque/incline/cadence factors from shadow copies
// MUL1  | prod = torque_pos * incline_lim
// MUL2  | prod = prod[20:0] * cadence_factor
// MUL3  | prod = prod[26:0] * scale
// SAT   | saturate into target_curr, pulse done, may accept the next start
module desired_drive_seq #(
  parameter logic [11:0] TORQUE_MIN = 12'h380
) (
  input logic                clk,
  input logic                rst_n,
  desired_drive_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    MUL3 = 3'd4,
    SAT  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] torque_sh_q, torque_sh_d;
  logic [4:0]  cadence_sh_q, cadence_sh_d;
  logic        np_sh_q, np_sh_d;
  logic [12:0] incline_sh_q, incline_sh_d;
  logic [2:0]  scale_sh_q, scale_sh_d;
  logic [11:0] torque_pos_q, torque_pos_d;
  logic [8:0]  incline_lim_q, incline_lim_d;
  logic [5:0]  cadence_factor_q, cadence_factor_d;
  logic [29:0] prod_q, prod_d;
  logic [11:0] target_q, target_d;
  logic        done_q, done_d;

  logic [12:0] torque_diff;
  logic [11:0] torque_pos_c;
  logic [9:0]  incline_sat_c;
  logic [10:0] incline_factor_c;
  logic [8:0]  incline_lim_c;
  logic [5:0]  cadence_factor_c;
  logic [26:0] mul_a;
  logic [8:0]  mul_b;
  logic [35:0] mul_p;
  logic        accept;

  // Factor derivation from the shadow registers; only consumed in PREP.
  always_comb begin
    torque_diff  = {1'b0, torque_sh_q} - {1'b0, TORQUE_MIN};
    torque_pos_c = torque_diff[12] ? 12'd0 : torque_diff[11:0];

    if (!incline_sh_q[12] && (incline_sh_q[11:9] != 3'b000)) begin
      incline_sat_c = 10'h1FF;
    end else if (incline_sh_q[12] && (incline_sh_q[11:9] != 3'b111)) begin
      incline_sat_c = 10'h200;
    end else begin
      incline_sat_c = incline_sh_q[9:0];
    end

    incline_factor_c = {incline_sat_c[9], incline_sat_c} + 11'd256;
    if (incline_factor_c[10]) begin
      incline_lim_c = 9'd0;
    end else if (incline_factor_c[9]) begin
      incline_lim_c = 9'h1FF;
    end else begin
      incline_lim_c = incline_factor_c[8:0];
    end

    cadence_factor_c = (cadence_sh_q > 5'd1) ? ({1'b0, cadence_sh_q} + 6'd32) : 6'd0;
  end

  // Operand muxes for the single shared multiplier.
  always_comb begin
    mul_a = 27'd0;
    mul_b = 9'd0;
    case (state_q)
      MUL1: begin
        mul_a = {15'd0, torque_pos_q};
        mul_b = incline_lim_q;
      end
      MUL2: begin
        mul_a = {6'd0, prod_q[20:0]};
        mul_b = {3'd0, cadence_factor_q};
      end
      MUL3: begin
        mul_a = prod_q[26:0];
        mul_b = {6'd0, scale_sh_q};
      end
      default: begin
        mul_a = 27'd0;
        mul_b = 9'd0;
      end
    endcase
  end

  assign mul_p = {9'd0, mul_a} * {27'd0, mul_b};

  // SAT counts as the return to IDLE, so a waiting start is taken there to keep 5-cycle throughput.
  assign accept = bus.start && ((state_q == IDLE) || (state_q == SAT));

  always_comb begin
    state_d          = state_q;
    torque_sh_d      = torque_sh_q;
    cadence_sh_d     = cadence_sh_q;
    np_sh_d          = np_sh_q;
    incline_sh_d     = incline_sh_q;
    scale_sh_d       = scale_sh_q;
    torque_pos_d     = torque_pos_q;
    incline_lim_d    = incline_lim_q;
    cadence_factor_d = cadence_factor_q;
    prod_d           = prod_q;
    target_d         = target_q;
    done_d           = 1'b0;

    case (state_q)
      IDLE: state_d = IDLE;
      PREP: begin
        torque_pos_d     = torque_pos_c;
        incline_lim_d    = incline_lim_c;
        cadence_factor_d = cadence_factor_c;
        state_d          = MUL1;
      end
      MUL1: begin
        prod_d  = mul_p[29:0];
        state_d = MUL2;
      end
      MUL2: begin
        prod_d  = mul_p[29:0];
        state_d = MUL3;
      end
      MUL3: begin
        prod_d  = mul_p[29:0];
        state_d = SAT;
      end
      SAT: begin
        if (np_sh_q) begin
          target_d = 12'd0;
        end else if (prod_q[29:27] != 3'b000) begin
          target_d = 12'hFFF;
        end else begin
          target_d = prod_q[26:15];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      torque_sh_d  = bus.avg_torque;
      cadence_sh_d = bus.cadence;
      np_sh_d      = bus.not_pedaling;
      incline_sh_d = bus.incline;
      scale_sh_d   = bus.scale;
      state_d      = PREP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      torque_sh_q      <= 12'd0;
      cadence_sh_q     <= 5'd0;
      np_sh_q          <= 1'b0;
      incline_sh_q     <= 13'd0;
      scale_sh_q       <= 3'd0;
      torque_pos_q     <= 12'd0;
      incline_lim_q    <= 9'd0;
      cadence_factor_q <= 6'd0;
      prod_q           <= 30'd0;
      target_q         <= 12'd0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      torque_sh_q      <= torque_sh_d;
      cadence_sh_q     <= cadence_sh_d;
      np_sh_q          <= np_sh_d;
      incline_sh_q     <= incline_sh_d;
      scale_sh_q       <= scale_sh_d;
      torque_pos_q     <= torque_pos_d;
      incline_lim_q    <= incline_lim_d;
      cadence_factor_q <= cadence_factor_d;
      prod_q           <= prod_d;
      target_q         <= target_d;
      done_q           <= done_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.target_curr = target_q;

endmodule

// File: tb/tb_desired_drive_seq.sv
// Scoreboard bench for desired_drive_seq: stimulus pushes expected results, a negedge monitor pops on done.
module tb_desired_drive_seq;

  typedef struct {
    logic [11:0] val;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  desired_drive_seq_if intf();

  desired_drive_seq #(.TORQUE_MIN(12'h380)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_n   = 0;
  int          free_at  = 0;
  logic [11:0] exp_hold = 12'd0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  // Reference: clamp and multiply with plain integers.
  function automatic logic [11:0] model(input int t, input int c, input bit np,
                                        input logic [12:0] inc, input int s);
    int     tp;
    int     iv;
    int     f;
    int     cf;
    longint p;
    tp = t - 'h380;
    if (tp < 0) tp = 0;
    iv = $signed(inc);
    if (iv > 511) iv = 511;
    if (iv < -512) iv = -512;
    f = iv + 256;
    if (f < 0) f = 0;
    if (f > 511) f = 511;
    cf = (c > 1) ? c + 32 : 0;
    p = longint'(tp) * f * cf * s;
    if (np) return 12'd0;
    if (p >= (longint'(1) << 27)) return 12'hFFF;
    return 12'(p >> 15);
  endfunction

  task automatic step(input logic st);
    exp_t e;
    intf.start = st;
    @(posedge clk);
    edge_n++;
    if (rst_n && st && edge_n >= free_at) begin
      e.val = model(intf.avg_torque, intf.cadence, intf.not_pedaling, intf.incline, intf.scale);
      e.due = edge_n + 5;
      sb_q.push_back(e);
      free_at = edge_n + 5;
    end
    #2;
  endtask

  task automatic set_in(input logic [11:0] t, input logic [4:0] c, input logic np,
                        input logic [12:0] inc, input logic [2:0] s);
    intf.avg_torque   = t;
    intf.cadence      = c;
    intf.not_pedaling = np;
    intf.incline      = inc;
    intf.scale        = s;
  endtask

  task automatic nominal();
    set_in(12'h700, 5'd16, 1'b0, 13'h0000, 3'd3);
  endtask

  task automatic pulse_and_wait();
    step(1'b1);
    repeat (6) step(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_q.delete();
    free_at = 0;
    #1;
    chk("reset_busy", intf.busy, 0);
    chk("reset_done", intf.done, 0);
    chk("reset_target", intf.target_curr, 0);
    repeat (2) step(1'b0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_hold = 12'd0;
    end else begin
      chk("busy", intf.busy, (edge_n < free_at) ? 1 : 0);
      if (intf.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("target_curr", intf.target_curr, e.val);
          chk("done_latency", edge_n, e.due);
          exp_hold = e.val;
        end
      end else begin
        chk("target_hold", intf.target_curr, exp_hold);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    intf.start = 1'b0;
    nominal();
    #1;
    chk("por_busy", intf.busy, 0);
    chk("por_done", intf.done, 0);
    chk("por_target", intf.target_curr, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    nominal();
    pulse_and_wait();

    set_in(12'hFFF, 5'd31, 1'b0, 13'h00FF, 3'd7);
    pulse_and_wait();
    nominal();
    intf.incline = 13'h0800;
    pulse_and_wait();

    nominal(); intf.avg_torque = 12'h200;  pulse_and_wait();
    nominal(); intf.cadence = 5'd1;        pulse_and_wait();
    nominal(); intf.incline = 13'h1F00;    pulse_and_wait();
    nominal(); intf.incline = 13'h1000;    pulse_and_wait();
    nominal(); intf.not_pedaling = 1'b1;   pulse_and_wait();

    // Second start and input churn while busy must be ignored.
    nominal();
    step(1'b1);
    step(1'b0);
    intf.scale = 3'd7;
    step(1'b1);
    set_in(12'hFFF, 5'd31, 1'b1, 13'h1000, 3'd0);
    repeat (6) step(1'b0);

    nominal();
    repeat (12) step(1'b1);
    repeat (7) step(1'b0);

    // Reset while in MUL2 after a 12'h3F0 result.
    nominal();
    pulse_and_wait();
    step(1'b1);
    step(1'b0);
    step(1'b0);
    do_reset();
    nominal();
    pulse_and_wait();

    for (int i = 0; i < 400; i++) begin
      logic [11:0] t;
      t = ($urandom_range(0, 3) == 0) ? 12'(12'h300 + $urandom_range(0, 255)) : 12'($urandom);
      set_in(t, 5'($urandom), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 1023) - 512) : 13'($urandom),
             3'($urandom));
      step($urandom_range(0, 2) == 0);
    end
    repeat (8) step(1'b0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
